ct_spsram_pipe_init: RTL

//  Parametrised single-port SRAM (behavioural array) keeping the CEN/GWEN/bit-WEN

---
 rtl/ct_spsram_pipe_init.sv | 175 +++++++++++++++++
 1 files changed

// File: rtl/ct_spsram_pipe_init.sv
// ct_spsram_pipe_init
// Behavioural single-port SRAM with the active-low CEN/GWEN/bit-WEN macro interface.
// It adds a read latency of 1 or 2 cycles with a read-valid strobe, and a hardware
// clear engine that fills every entry with INIT_VAL after reset or on an INIT_REQ pulse.
// While the clear sweep runs, INIT_BUSY is high and all accesses are dropped.
module ct_spsram_pipe_init #(
    parameter int                    ADDR_WIDTH = 10,
    parameter int                    DATA_WIDTH = 64,
    parameter int                    DEPTH      = 1024,
    parameter int                    RD_LAT     = 1,
    parameter int                    INIT_EN    = 1,
    parameter logic [DATA_WIDTH-1:0] INIT_VAL   = '0
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [ADDR_WIDTH-1:0] A,
    input  logic                  CEN,
    input  logic                  GWEN,
    input  logic [DATA_WIDTH-1:0] WEN,
    input  logic [DATA_WIDTH-1:0] D,
    input  logic                  INIT_REQ,
    output logic [DATA_WIDTH-1:0] Q,
    output logic                  QVLD,
    output logic                  INIT_BUSY
);

    // Index width is sized to the array, so addresses at or above DEPTH must be
    // filtered explicitly before the low bits are used as an index.
    localparam int                  IDX_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_WIDTH:0] DEPTH_W  = (ADDR_WIDTH + 1)'(DEPTH);
    localparam logic [IDX_W-1:0]    LAST_IDX = IDX_W'(DEPTH - 1);

    // Reject illegal configurations at elaboration time.
    generate
        if (!(RD_LAT == 1 || RD_LAT == 2)) begin : g_bad_rd_lat
            $error("ct_spsram_pipe_init: RD_LAT must be 1 or 2");
        end
        if (DEPTH < 2 || DEPTH > (1 << ADDR_WIDTH)) begin : g_bad_depth
            $error("ct_spsram_pipe_init: DEPTH must satisfy 2 <= DEPTH <= 2**ADDR_WIDTH");
        end
    endgenerate

    typedef enum logic {
        S_IDLE = 1'b0,
        S_INIT = 1'b1
    } state_t;

    state_t                  r_state;
    state_t                  w_state_nxt;
    logic [IDX_W-1:0]        r_cnt;
    logic [DATA_WIDTH-1:0]   r_mem [DEPTH];

    logic                    w_sweep_wr;
    logic                    w_acc;
    logic                    w_in_range;
    logic [IDX_W-1:0]        w_idx;
    logic                    w_wr_en;
    logic                    w_rd_en;
    logic [DATA_WIDTH-1:0]   w_rd_data;
    logic                    w_q_vld_in;
    logic [DATA_WIDTH-1:0]   w_q_data_in;

    // FSM state register; reset lands in INIT so the array is cleared before first use.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state <= (INIT_EN != 0) ? S_INIT : S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // FSM next state: a request starts the sweep, the write to the last entry ends it.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (INIT_REQ) begin
                    w_state_nxt = S_INIT;
                end
            end
            S_INIT: begin
                if (r_cnt == LAST_IDX) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // FSM outputs: busy flag, sweep write strobe and the access gate.
    always_comb begin
        INIT_BUSY  = (r_state == S_INIT);
        w_sweep_wr = (r_state == S_INIT);
        w_acc      = (r_state == S_IDLE) && !CEN;
    end

    // Clear counter: walks every entry during INIT, rearmed to 0 by a request in IDLE.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_cnt <= '0;
        end else if (r_state == S_INIT) begin
            r_cnt <= (r_cnt == LAST_IDX) ? '0 : r_cnt + 1'b1;
        end else if (INIT_REQ) begin
            r_cnt <= '0;
        end
    end

    // Access decode; out-of-range addresses never touch the array and read as zero.
    always_comb begin
        w_in_range = ({1'b0, A} < DEPTH_W);
        w_idx      = A[IDX_W-1:0];
        w_wr_en    = w_acc && !GWEN && w_in_range;
        w_rd_en    = w_acc && GWEN;
        w_rd_data  = '0;
        if (w_in_range) begin
            w_rd_data = r_mem[w_idx];
        end
    end

    // Array update: sweep writes INIT_VAL, otherwise a bit-masked write (WEN low = write bit).
    always_ff @(posedge CLK) begin
        if (w_sweep_wr) begin
            r_mem[r_cnt] <= INIT_VAL;
        end else if (w_wr_en) begin
            r_mem[w_idx] <= (r_mem[w_idx] & WEN) | (D & ~WEN);
        end
    end

    // The array is sampled at the request edge in both latencies, so a write issued
    // in the following cycle cannot disturb a read already in the pipe.
    generate
        if (RD_LAT == 2) begin : g_lat2
            logic                  r_vld_p0;
            logic [DATA_WIDTH-1:0] r_rd_data_p0;

            // Stage p0 valid: flushed by reset so in-flight reads are discarded.
            always_ff @(posedge CLK) begin
                if (RST) begin
                    r_vld_p0 <= 1'b0;
                end else begin
                    r_vld_p0 <= w_rd_en;
                end
            end

            // Stage p0 data: captured only for accepted reads.
            always_ff @(posedge CLK) begin
                if (w_rd_en) begin
                    r_rd_data_p0 <= w_rd_data;
                end
            end

            assign w_q_vld_in  = r_vld_p0;
            assign w_q_data_in = r_rd_data_p0;
        end else begin : g_lat1
            assign w_q_vld_in  = w_rd_en;
            assign w_q_data_in = w_rd_data;
        end
    endgenerate

    // Output stage: QVLD pulses per delivered read, Q holds its value between reads.
    always_ff @(posedge CLK) begin
        if (RST) begin
            Q    <= '0;
            QVLD <= 1'b0;
        end else begin
            QVLD <= w_q_vld_in;
            if (w_q_vld_in) begin
                Q <= w_q_data_in;
            end
        end
    end

endmodule
